// File: rtl/reg_file_wb_pkg.sv
// Shared register-file definitions, also used by the ID/EX buffer and hazard unit.
package reg_file_wb_pkg;

    localparam int REG_DATA_W   = 16;
    localparam int REG_NUM      = 16;
    localparam int REG_ADDR_W   = 4;
    localparam int REG_ZERO_IDX = 0;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : reg_file_wb_pkg

// File: rtl/reg_file_wb_reg_word.sv
// reg_word: one architectural register, write-enabled, async active-low clear.
module reg_word #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Hold value; load on write enable; clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_q <= '0;
        else if (i_we) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule : reg_word

// File: rtl/reg_file_wb.sv
// reg_file_wb: 16x16 register file, 2 async read ports, 1 sync write port.
// R0 is a constant zero. Optional same-cycle write-to-read bypass is
// enabled by defining REG_FILE_WB_BYPASS_EN.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = REG_NUM,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] srcReg1,
    input  logic [ADDR_W-1:0] srcReg2,
    input  logic [ADDR_W-1:0] dstReg,
    input  logic              writeReg,
    input  logic [DATA_W-1:0] dstData,
    output logic [DATA_W-1:0] srcData1,
    output logic [DATA_W-1:0] srcData2
);

    logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;
    logic [NUM_REGS-1:0]             w_we;
    logic                            w_wr_valid;

    // A write to R0 is never a real write; it must not load or bypass.
    assign w_wr_valid = writeReg && (dstReg != ADDR_W'(REG_ZERO_IDX));

    // R0 has no storage.
    assign w_regs[0] = '0;
    assign w_we[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            assign w_we[gi] = w_wr_valid && (dstReg == ADDR_W'(gi));

            reg_word #(.DATA_W(DATA_W)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .i_we  (w_we[gi]),
                .i_d   (dstData),
                .o_q   (w_regs[gi])
            );
        end
    endgenerate

`ifdef REG_FILE_WB_BYPASS_EN
    // Read muxes with write-before-read forwarding; suppressed during reset
    // so outputs stay zero while rst_n is low.
    always_comb begin
        srcData1 = w_regs[srcReg1];
        srcData2 = w_regs[srcReg2];
        if (rst_n && w_wr_valid && (srcReg1 == dstReg)) srcData1 = dstData;
        if (rst_n && w_wr_valid && (srcReg2 == dstReg)) srcData2 = dstData;
    end
`else
    // Read muxes return stored contents only; same-cycle reads see old value.
    always_comb begin
        srcData1 = w_regs[srcReg1];
        srcData2 = w_regs[srcReg2];
    end
`endif

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  srcReg1, srcReg2, dstReg;
    logic        writeReg;
    logic [15:0] dstData;
    logic [15:0] srcData1, srcData2;

    logic [15:0] mdl [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    reg_file_wb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .srcReg1  (srcReg1),
        .srcReg2  (srcReg2),
        .dstReg   (dstReg),
        .writeReg (writeReg),
        .dstData  (dstData),
        .srcData1 (srcData1),
        .srcData2 (srcData2)
    );

    always #5 clk = ~clk;

    // Expected read value from the architectural state plus current inputs.
    function automatic logic [15:0] exp_rd(input logic [3:0] idx);
        logic [15:0] v;
        if (!rst_n || idx == 4'd0) return 16'h0000;
        v = mdl[idx];
`ifdef REG_FILE_WB_BYPASS_EN
        if (writeReg && dstReg != 4'd0 && dstReg == idx) v = dstData;
`endif
        return v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_p1"}, srcData1, exp_rd(srcReg1));
        check({tag, "_p2"}, srcData2, exp_rd(srcReg2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    endtask

    // Clock edge: architectural effect of a write, then settle past the edge.
    task automatic edge_update();
        @(posedge clk);
        if (!rst_n) clear_model();
        else if (writeReg && dstReg != 4'd0) mdl[dstReg] = dstData;
        #1;
    endtask

    // One full cycle: drive, check mid-cycle, advance through the edge.
    task automatic cyc(input string tag, input logic w, input logic [3:0] d,
                       input logic [15:0] data, input logic [3:0] s1, input logic [3:0] s2);
        writeReg = w; dstReg = d; dstData = data; srcReg1 = s1; srcReg2 = s2;
        #3;
        check_ports(tag);
        edge_update();
    endtask

    initial begin
        clear_model();
        rst_n = 1'b0; writeReg = 1'b0; dstReg = '0; dstData = '0; srcReg1 = '0; srcReg2 = '0;
        #1;
        // Reset held: every index reads zero, writes at the edge are lost.
        for (int i = 0; i < 16; i++) begin
            cyc("rst_probe", 1'b1, 4'(i), 16'hDEAD, 4'(i), 4'(15 - i));
            check("rst_const_p1", srcData1, 16'h0000);
        end
        // Deassert before the edge: the write to R4 happens.
        writeReg = 1'b1; dstReg = 4'd4; dstData = 16'h4444; srcReg1 = 4'd4; srcReg2 = 4'd0;
        #2 rst_n = 1'b1;
        #1 check_ports("rst_rise");
        edge_update();
        cyc("rst_rise_after", 1'b0, 4'd0, 16'h0, 4'd4, 4'd4);
        check("r4_const", srcData1, 16'h4444);

        // Basic write/read.
        cyc("wr_r3", 1'b1, 4'd3, 16'hA5A5, 4'd1, 4'd2);
        cyc("wr_r15", 1'b1, 4'd15, 16'h1234, 4'd3, 4'd14);
        cyc("rd_basic", 1'b0, 4'd0, 16'h0, 4'd3, 4'd15);
        check("r3_const", srcData1, 16'hA5A5);
        check("r15_const", srcData2, 16'h1234);
        for (int i = 0; i < 16; i++) cyc("rd_all", 1'b0, 4'd0, 16'h0, 4'(i), 4'(i));

        // R0 protection.
        cyc("r0_wr", 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
        cyc("r0_after", 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
        check("r0_const", srcData1, 16'h0000);

        // Write-enable gating.
        cyc("we_gate", 1'b0, 4'd5, 16'hBEEF, 4'd5, 4'd5);
        cyc("we_gate_after", 1'b0, 4'd5, 16'hBEEF, 4'd5, 4'd5);
        check("r5_const", srcData1, 16'h0000);

        // Same-cycle read of the write target.
        cyc("r7_init", 1'b1, 4'd7, 16'h0001, 4'd0, 4'd0);
        writeReg = 1'b1; dstReg = 4'd7; dstData = 16'h0002; srcReg1 = 4'd7; srcReg2 = 4'd7;
        #3;
        check_ports("r7_same");
`ifdef REG_FILE_WB_BYPASS_EN
        check("r7_same_const", srcData2, 16'h0002);
`else
        check("r7_same_const", srcData2, 16'h0001);
`endif
        edge_update();
        cyc("r7_next", 1'b0, 4'd0, 16'h0, 4'd7, 4'd7);
        check("r7_next_const", srcData1, 16'h0002);

        // Back-to-back writes.
        cyc("b2b_1", 1'b1, 4'd1, 16'h0011, 4'd1, 4'd2);
        cyc("b2b_2", 1'b1, 4'd1, 16'h0022, 4'd1, 4'd2);
        cyc("b2b_3", 1'b1, 4'd2, 16'h0033, 4'd1, 4'd2);
        cyc("b2b_rd", 1'b0, 4'd0, 16'h0, 4'd1, 4'd2);
        check("r1_const", srcData1, 16'h0022);
        check("r2_const", srcData2, 16'h0033);

        // Randomized traffic against the model, biased toward hazards.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] d;
            logic [3:0] s1;
            d  = 4'($urandom_range(0, 15));
            s1 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
            cyc("rand", 1'($urandom_range(0, 1)), d, 16'($urandom), s1, 4'($urandom_range(0, 15)));
        end

        // Mid-cycle reset clears immediately, no clock needed.
        cyc("pre_rst", 1'b0, 4'd0, 16'h0, 4'd3, 4'd15);
        writeReg = 1'b1; dstReg = 4'd3; dstData = 16'h7777; srcReg1 = 4'd1; srcReg2 = 4'd2;
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        check_ports("mid_rst");
        check("mid_rst_const", srcData2, 16'h0000);
        edge_update();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) cyc("post_rst", 1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reg_file_wb
